fetch_sequencer: RTL and testbench

//   Front end that feeds the control decoder: fetches instruction bytes,

---
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : Instruction fetch front end; holds inst/cycle for decode and
//             sequences FETCH/EXEC0/EXEC1 with PC advance and jump redirect.
//  Revision : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          mem_data,
    input  logic                mem_ready,
    input  logic                hold,
    input  logic                MC,
    input  logic                J,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          inst,
    output logic                cycle,
    output logic                inst_valid,
    output logic                fetch_req,
    output logic                bus_data
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC0 = 2'b01,
        EXEC1 = 2'b10
    } state_t;

    localparam logic [PC_WIDTH-1:0] C_PC_ONE = PC_WIDTH'(1);

    state_t              rState;
    logic [PC_WIDTH-1:0] rPc;
    logic [7:0]          rInst;
    logic                rCycle;
    logic                rInstValid;
    logic                rFetchReq;
    logic                rBusData;
    logic                wMemOp;
    logic                wExec1Stall;

    // Opcodes 10xx_xxxx touch data memory during their second cycle.
    assign wMemOp      = rInst[7] & ~rInst[6];
    assign wExec1Stall = hold | (rBusData & ~mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rState     <= FETCH;
            rPc        <= RESET_VECTOR;
            rInst      <= 8'h00;
            rCycle     <= 1'b0;
            rInstValid <= 1'b0;
            rFetchReq  <= 1'b0;
            rBusData   <= 1'b0;
        end else begin
            case (rState)
                FETCH: begin
                    rFetchReq  <= 1'b1;
                    rInstValid <= 1'b0;
                    rBusData   <= 1'b0;
                    rCycle     <= 1'b0;
                    // No capture until the request has actually been on the bus.
                    if (rFetchReq && mem_ready && !hold) begin
                        rInst      <= mem_data;
                        rPc        <= rPc + C_PC_ONE;
                        rFetchReq  <= 1'b0;
                        rInstValid <= 1'b1;
                        rState     <= EXEC0;
                    end
                end
                EXEC0: begin
                    if (!hold) begin
                        if (MC) begin
                            rCycle   <= 1'b1;
                            rBusData <= wMemOp;
                            rState   <= EXEC1;
                        end else begin
                            rInstValid <= 1'b0;
                            rFetchReq  <= 1'b1;
                            rState     <= FETCH;
                        end
                    end
                end
                EXEC1: begin
                    if (!wExec1Stall) begin
                        if (J) begin
                            rPc <= jump_target;
                        end
                        rCycle     <= 1'b0;
                        rBusData   <= 1'b0;
                        rInstValid <= 1'b0;
                        rFetchReq  <= 1'b1;
                        rState     <= FETCH;
                    end
                end
                default: begin
                    rCycle     <= 1'b0;
                    rBusData   <= 1'b0;
                    rInstValid <= 1'b0;
                    rFetchReq  <= 1'b1;
                    rState     <= FETCH;
                end
            endcase
        end
    end

    assign pc         = rPc;
    assign inst       = rInst;
    assign cycle      = rCycle;
    assign inst_valid = rInstValid;
    assign fetch_req  = rFetchReq;
    assign bus_data   = rBusData;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Brief    : Vector table plus scoreboard bench for fetch_sequencer.
//  Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        hold;
    logic        MC;
    logic        J;
    logic [15:0] jump_target;
    logic [15:0] pc;
    logic [7:0]  inst;
    logic        cycle;
    logic        inst_valid;
    logic        fetch_req;
    logic        bus_data;

    fetch_sequencer #(.PC_WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .mem_data(mem_data), .mem_ready(mem_ready),
        .hold(hold), .MC(MC), .J(J), .jump_target(jump_target), .pc(pc),
        .inst(inst), .cycle(cycle), .inst_valid(inst_valid),
        .fetch_req(fetch_req), .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        mc;
        logic        j;
        logic [15:0] target;
        int          memWait;
        logic        expBus;
        logic        jEarly;
    } vec_t;

    typedef struct {
        logic [7:0]  inst;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        popped;
    vec_t        vecs[7];
    int          nChecks = 0;
    int          nPass   = 0;
    logic [15:0] mPc;
    logic        prevValid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Each newly valid instruction must match the oldest completed fetch.
    always @(negedge clk) begin
        if (inst_valid && !prevValid) begin
            if (sb.size() == 0) begin
                nChecks++;
                $display("FAIL sb_empty: got inst %h expected no instruction", inst);
            end else begin
                popped = sb.pop_front();
                check("sb_inst", 32'(inst), 32'(popped.inst));
                check("sb_pc", 32'(pc), 32'(popped.pc));
            end
        end
        prevValid = inst_valid;
    end

    task automatic runInst(input vec_t v);
        check("fetch_req", 32'(fetch_req), 32'd1);
        check("fetch_pc", 32'(pc), 32'(mPc));
        mem_data  = v.data;
        mem_ready = 1'b1;
        MC        = 1'b0;
        J         = 1'b0;
        sb.push_back('{v.data, mPc + 16'd1});
        tick();
        mPc       = mPc + 16'd1;
        mem_ready = 1'b0;
        mem_data  = 8'hFF;
        check("exec0_cycle", 32'(cycle), 32'd0);
        check("exec0_fetch_req", 32'(fetch_req), 32'd0);
        MC          = v.mc;
        J           = v.jEarly;
        jump_target = 16'hBEEF;
        tick();
        MC = 1'b0;
        J  = 1'b0;
        if (v.mc) begin
            check("exec1_cycle", 32'(cycle), 32'd1);
            check("exec1_bus", 32'(bus_data), 32'(v.expBus));
            for (int i = 0; i < v.memWait; i++) begin
                tick();
                check("exec1_wait_cycle", 32'(cycle), 32'd1);
                check("exec1_wait_pc", 32'(pc), 32'(mPc));
            end
            mem_ready   = v.expBus;
            J           = v.j;
            jump_target = v.target;
            tick();
            mem_ready = 1'b0;
            J         = 1'b0;
            if (v.j) mPc = v.target;
        end
        check("retire_valid", 32'(inst_valid), 32'd0);
        check("retire_cycle", 32'(cycle), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h4A, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
        vecs[1] = '{8'h85, 1'b1, 1'b0, 16'h0000, 3, 1'b1, 1'b0};
        vecs[2] = '{8'hE0, 1'b1, 1'b1, 16'h1234, 0, 1'b0, 1'b1};
        vecs[3] = '{8'h12, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b1, 16'hFFFF, 0, 1'b0, 1'b0};
        vecs[5] = '{8'h4A, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0};
        vecs[6] = '{8'h90, 1'b1, 1'b1, 16'h0001, 1, 1'b1, 1'b0};

        rst_n = 1'b0; mem_data = 8'h00; mem_ready = 1'b0; hold = 1'b0;
        MC = 1'b0; J = 1'b0; jump_target = 16'h0000;
        #12;
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_inst", 32'(inst), 32'h00);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_fetch_req", 32'(fetch_req), 32'd0);
        check("rst_bus", 32'(bus_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_first_fetch", 32'(fetch_req), 32'd0);
        tick();
        mPc = 16'h0000;

        foreach (vecs[k]) runInst(vecs[k]);

        // Stall: hold in every state; data offered while held must be dropped.
        hold = 1'b1; mem_ready = 1'b1; mem_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_fetch_valid", 32'(inst_valid), 32'd0);
            check("hold_fetch_pc", 32'(pc), 32'(mPc));
            check("hold_fetch_inst", 32'(inst), 32'h90);
        end
        hold = 1'b0; mem_data = 8'h81;
        sb.push_back('{8'h81, mPc + 16'd1});
        tick();
        mPc = mPc + 16'd1;
        mem_ready = 1'b0; hold = 1'b1; MC = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_exec0_cycle", 32'(cycle), 32'd0);
            check("hold_exec0_inst", 32'(inst), 32'h81);
            check("hold_exec0_valid", 32'(inst_valid), 32'd1);
        end
        hold = 1'b0;
        tick();
        MC = 1'b0;
        check("exec1_entry_cycle", 32'(cycle), 32'd1);
        check("exec1_entry_bus", 32'(bus_data), 32'd1);
        hold = 1'b1; mem_ready = 1'b1; J = 1'b1; jump_target = 16'hABCD;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_exec1_cycle", 32'(cycle), 32'd1);
            check("hold_exec1_pc", 32'(pc), 32'(mPc));
        end
        hold = 1'b0; J = 1'b0;
        tick();
        mem_ready = 1'b0;
        check("hold_release_valid", 32'(inst_valid), 32'd0);
        check("hold_release_pc", 32'(pc), 32'(mPc));

        // Asynchronous reset while stalled in the second cycle of a memory op.
        mem_data = 8'h85; mem_ready = 1'b1;
        sb.push_back('{8'h85, mPc + 16'd1});
        tick();
        mem_ready = 1'b0; MC = 1'b1;
        tick();
        MC = 1'b0;
        check("pre_rst_cycle", 32'(cycle), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc), 32'h0000);
        check("async_rst_cycle", 32'(cycle), 32'd0);
        check("async_rst_valid", 32'(inst_valid), 32'd0);
        check("async_rst_bus", 32'(bus_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_fetch_req", 32'(fetch_req), 32'd1);
        check("post_rst_pc", 32'(pc), 32'h0000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
